// File: rtl/fpu_pkg.sv
// Shared FPU types: IEEE-754 single field layout, special encodings and subtractor FSM states.
// Pure declarations; no timing or backpressure of its own.
package fpu_pkg;

  localparam int EXP_BIAS   = 127;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int MANT_EXT_W = 27;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_NORM,
    ST_PACK
  } fsm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic [31:0] signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  function automatic logic [4:0] lead_zeros(input logic [MANT_EXT_W-1:0] m);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = MANT_EXT_W - 1; i >= 0; i--) begin
      if (!found && !m[i]) n = n + 5'd1;
      else                 found = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational 27-bit right barrel shifter; sticky is the OR of every bit shifted out.
// Zero latency, no flow control; shifts of 27 or more leave only the sticky bit.
module fp_align_shift
  import fpu_pkg::*;
(
  input  logic [MANT_EXT_W-1:0] din,
  input  logic [7:0]            shamt,
  output logic [MANT_EXT_W-1:0] dout,
  output logic                  sticky
);

  logic [2*MANT_EXT_W-1:0] wide;

  always_comb begin
    wide   = '0;
    dout   = '0;
    sticky = 1'b0;
    if (shamt >= 8'd27) begin
      sticky = |din;
    end else begin
      wide   = {din, {MANT_EXT_W{1'b0}}} >> shamt;
      dout   = wide[2*MANT_EXT_W-1:MANT_EXT_W];
      sticky = |wide[MANT_EXT_W-1:0];
    end
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision a - b, round toward zero; 3 + ceil(lz/NORM_STEP) cycles, specials 2.
// start is taken only while idle (busy=0); a start during an operation is dropped, not queued.
module fp_subtractor_seq
  import fpu_pkg::*;
#(
  parameter int NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  fsm_state_t            state;
  fp32_t                 a_q, b_q;
  logic                  sign_r, eff_sub_r, special_r;
  logic [31:0]           spec_val_r;
  logic signed [9:0]     exp_r;
  logic [MANT_EXT_W-1:0] mant_r, sml_r;
  logic [7:0]            diff_r;

  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge, bsign;
  logic [FRAC_W-1:0]     fa, fb;
  logic                  is_spec;
  logic [31:0]           spec_val;

  // Classification of the captured operands; denormals are flushed to zero here.
  always_comb begin
    a_zero = (a_q.exp == '0);
    b_zero = (b_q.exp == '0);
    a_inf  = (a_q.exp == '1) && (a_q.frac == '0);
    b_inf  = (b_q.exp == '1) && (b_q.frac == '0);
    a_nan  = (a_q.exp == '1) && (a_q.frac != '0);
    b_nan  = (b_q.exp == '1) && (b_q.frac != '0);
    fa     = a_zero ? '0 : a_q.frac;
    fb     = b_zero ? '0 : b_q.frac;
    bsign  = ~b_q.sign;
    a_ge   = ({a_q.exp, fa} >= {b_q.exp, fb});

    is_spec  = 1'b1;
    spec_val = '0;
    if (a_nan || b_nan)      spec_val = QNAN;
    else if (a_inf && b_inf) spec_val = (a_q.sign == b_q.sign) ? QNAN : signed_inf(a_q.sign);
    else if (a_inf)          spec_val = signed_inf(a_q.sign);
    else if (b_inf)          spec_val = signed_inf(bsign);
    else if (a_zero && b_zero) spec_val = {a_q.sign & bsign, 31'b0};
    else if (a_q == b_q)     spec_val = '0;
    else                     is_spec  = 1'b0;
  end

  logic [MANT_EXT_W-1:0] al_m, sm, dif, al_mant;
  logic                  al_s, al_inc;
  logic [MANT_EXT_W:0]   sum;

  fp_align_shift u_align (
    .din    (sml_r),
    .shamt  (diff_r),
    .dout   (al_m),
    .sticky (al_s)
  );

  always_comb begin
    sm      = al_m | {{(MANT_EXT_W-1){1'b0}}, al_s};
    sum     = {1'b0, mant_r} + {1'b0, sm};
    dif     = mant_r - sm;
    al_inc  = 1'b0;
    al_mant = eff_sub_r ? dif : sum[MANT_EXT_W-1:0];
    if (!eff_sub_r && sum[MANT_EXT_W]) begin
      al_mant = {sum[MANT_EXT_W:2], sum[1] | sum[0]};
      al_inc  = 1'b1;
    end
  end

  logic [4:0] lz, sh;

  always_comb begin
    lz = lead_zeros(mant_r);
    sh = (lz < 5'(NORM_STEP)) ? lz : 5'(NORM_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_r     <= 1'b0;
      eff_sub_r  <= 1'b0;
      special_r  <= 1'b0;
      spec_val_r <= '0;
      exp_r      <= '0;
      mant_r     <= '0;
      sml_r      <= '0;
      diff_r     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          special_r  <= is_spec;
          spec_val_r <= spec_val;
          sign_r     <= a_ge ? a_q.sign : bsign;
          eff_sub_r  <= (a_q.sign != bsign);
          exp_r      <= a_ge ? $signed({2'b00, a_q.exp}) : $signed({2'b00, b_q.exp});
          mant_r     <= a_ge ? {~a_zero, fa, 3'b000} : {~b_zero, fb, 3'b000};
          sml_r      <= a_ge ? {~b_zero, fb, 3'b000} : {~a_zero, fa, 3'b000};
          diff_r     <= a_ge ? (a_q.exp - b_q.exp) : (b_q.exp - a_q.exp);
          state      <= is_spec ? ST_PACK : ST_ALIGN;
        end
        ST_ALIGN: begin
          mant_r <= al_mant;
          if (al_inc) exp_r <= exp_r + 10'sd1;
          state  <= (al_mant[MANT_EXT_W-1] || al_mant == '0) ? ST_PACK : ST_NORM;
        end
        ST_NORM: begin
          mant_r <= mant_r << sh;
          exp_r  <= exp_r - $signed({5'b00000, sh});
          if (lz <= 5'(NORM_STEP)) state <= ST_PACK;
        end
        ST_PACK: begin
          if (special_r)                result <= spec_val_r;
          else if (mant_r == '0)        result <= '0;
          else if (exp_r >= 10'sd255)   result <= signed_inf(sign_r);
          else if (exp_r <= 10'sd0)     result <= {sign_r, 31'b0};
          else                          result <= {sign_r, exp_r[7:0], mant_r[MANT_EXT_W-2:3]};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: directed cases then random operands against an exact-integer model.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_subtractor_seq #(.NORM_STEP(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value of each operand as an integer in units of 2^-149, then truncate to 24 bits.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic         xs, ys, rs, xz, yz;
    logic [287:0] xm, ym, d, t;
    int           p, e;
    logic [7:0]   e8;
    xs = x[31];
    ys = ~y[31];
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0))
      return 32'h7FC00000;
    if (x[30:23] == 8'hFF && y[30:23] == 8'hFF)
      return (xs != ys) ? 32'h7FC00000 : {xs, 31'h7F800000};
    if (x[30:23] == 8'hFF) return {xs, 31'h7F800000};
    if (y[30:23] == 8'hFF) return {ys, 31'h7F800000};
    xz = (x[30:23] == 0);
    yz = (y[30:23] == 0);
    if (xz && yz) return {xs & ys, 31'b0};
    xm = xz ? '0 : (288'({1'b1, x[22:0]}) << (x[30:23] - 8'd1));
    ym = yz ? '0 : (288'({1'b1, y[22:0]}) << (y[30:23] - 8'd1));
    if (xs == ys)      begin d = xm + ym; rs = xs; end
    else if (xm >= ym) begin d = xm - ym; rs = xs; end
    else               begin d = ym - xm; rs = ys; end
    if (d == 0) return 32'h0;
    p = 0;
    for (int i = 287; i >= 0; i--) if (d[i]) begin p = i; break; end
    e = p - 22;
    if (e >= 255) return {rs, 31'h7F800000};
    if (e <= 0)   return {rs, 31'b0};
    t  = d >> (p - 23);
    e8 = 8'(e);
    return {rs, e8, t[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input bit poke,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    res = '0;
    for (int n = 1; n <= 40; n++) begin
      if (poke && n == 1) begin a = 32'h3F800000; b = 32'h40000000; start = 1'b1; end
      @(posedge clk); #1;
      if (poke && n == 1) start = 1'b0;
      if (done) begin lat = n; res = result; break; end
    end
    if (lat < 0) chk("done_timeout", 32'(done), 32'd1);
    else begin
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r, xa, xb;
    int          lat, dn;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    do_op(32'h40400000, 32'h3F800000, 1'b0, r, lat);
    chk("t1_res", r, 32'h40000000);
    chk("t1_lat", lat, 32'd3);

    do_op(32'h3F800000, 32'hBF800000, 1'b0, r, lat);
    chk("t2_res", r, 32'h40000000);
    chk("t2_lat", lat, 32'd3);

    do_op(32'h3F800000, 32'h3F7FFFFF, 1'b0, r, lat);
    chk("t3_res", r, 32'h33800000);
    chk("t3_lat", lat, 32'd27);

    do_op(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
    chk("t4_eq_res", r, 32'h00000000);
    chk("t4_eq_lat", lat, 32'd2);
    do_op(32'h7F800000, 32'h7F800000, 1'b0, r, lat);
    chk("t4_inf_res", r, 32'h7FC00000);
    chk("t4_inf_lat", lat, 32'd2);
    do_op(32'h80000000, 32'h00000000, 1'b0, r, lat);
    chk("negzero_res", r, 32'h80000000);
    do_op(32'h7FC00001, 32'h3F800000, 1'b0, r, lat);
    chk("nan_res", r, 32'h7FC00000);

    do_op(32'h7F7FFFFF, 32'hFF7FFFFF, 1'b0, r, lat);
    chk("t5_ovf_res", r, 32'h7F800000);
    do_op(32'h00800000, 32'h00C00000, 1'b0, r, lat);
    chk("t5_unf_res", r, 32'h80000000);

    // A second start while busy must be dropped.
    do_op(32'h40400000, 32'h3F800000, 1'b1, r, lat);
    chk("t6_busy_res", r, 32'h40000000);
    chk("t6_busy_lat", lat, 32'd3);
    chk("t6_idle_after", 32'(busy), 32'd0);

    // Reset while in the normalisation loop aborts without a done pulse.
    do_op(32'h3F800000, 32'h3F7FFFFF, 1'b0, r, lat);
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F7FFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    chk("abort_no_done", dn, 32'd0);
    do_op(32'h40400000, 32'h3F800000, 1'b0, r, lat);
    chk("post_abort_res", r, 32'h40000000);
    chk("post_abort_lat", lat, 32'd3);

    for (int i = 0; i < 300; i++) begin
      xa = $urandom;
      case ($urandom_range(0, 3))
        0: xb = $urandom;
        1: xb = xa ^ ($urandom & 32'h00FFFFFF) ^ (32'($urandom_range(0, 1)) << 31);
        2: begin
          xa[30:23] = 8'($urandom_range(0, 3));
          xb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 23'($urandom)};
        end
        default: begin
          xa[30:23] = 8'($urandom_range(252, 255));
          xb = {1'($urandom_range(0, 1)), 8'($urandom_range(252, 255)), 23'($urandom)};
        end
      endcase
      do_op(xa, xb, 1'b0, r, lat);
      chk($sformatf("rand_%0d_%h_%h", i, xa, xb), r, ref_sub(xa, xb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
